// File: rtl/btn_cmd_frontend.sv
// Push-button command front-end: sync + debounce btnl/btnr, issue write/read commands, latch read data on LEDs.
// Optional build macro BTN_CMD_COMPARE_EN adds a sticky read-vs-last-write mismatch flag.
module btn_cmd_frontend #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RD_TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnl,
  input  logic        btnr,
  input  logic [7:0]  switch,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_write,
  output logic [14:0] cmd_addr,
  output logic [15:0] cmd_data,
  input  logic        rd_valid,
  input  logic [15:0] rd_data,
  output logic [7:0]  led,
  output logic        busy,
  output logic        timeout
`ifdef BTN_CMD_COMPARE_EN
  ,
  output logic        mismatch
`endif
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TOW = $clog2(RD_TIMEOUT + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  // bit 0 = btnl (write), bit 1 = btnr (read)
  logic [1:0]     raw;
  logic [1:0]     sync_p0;
  logic [1:0]     sync_p1;
  logic [1:0]     level;
  logic [1:0]     level_d;
  logic [1:0]     press;
  logic [DBW-1:0] db_cnt [2];

  state_t         state;
  state_t         state_nx;
  logic [14:0]    wr_ptr;
  logic [14:0]    rd_ptr;
  logic [TOW-1:0] to_cnt;
  logic           to_hit;

  assign raw    = {btnr, btnl};
  assign to_hit = (to_cnt == TO_LAST);

  // Synchronizer, debouncer and rising-edge press detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      level     <= '0;
      level_d   <= '0;
      press     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Command FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (press[0] || press[1]) state_nx = ISSUE;
      ISSUE:   if (cmd_ready) state_nx = cmd_write ? IDLE : WAIT_RD;
      WAIT_RD: if (rd_valid || to_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cmd_valid <= (state_nx == ISSUE);
      busy      <= (state_nx != IDLE);
    end
  end

  // Command registers, pointers, read capture and timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      to_cnt    <= '0;
      led       <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // write wins over a simultaneous read event
          if (press[0]) begin
            cmd_write <= 1'b1;
            cmd_addr  <= wr_ptr;
            cmd_data  <= {~switch, switch};
          end else if (press[1]) begin
            cmd_write <= 1'b0;
            cmd_addr  <= rd_ptr;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            if (cmd_write) wr_ptr <= wr_ptr + 1'b1;
            to_cnt <= '0;
          end
        end
        WAIT_RD: begin
          if (rd_valid) begin
            led    <= rd_data[7:0];
            rd_ptr <= rd_ptr + 1'b1;
          end else if (to_hit) begin
            timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BTN_CMD_COMPARE_EN
  logic [15:0] last_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_wr  <= '0;
      mismatch <= 1'b0;
    end else begin
      if (state == ISSUE && cmd_ready && cmd_write) last_wr <= cmd_data;
      if (state == WAIT_RD && rd_valid && rd_data != last_wr) mismatch <= 1'b1;
    end
  end
`else
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data[15:8];
`endif

endmodule
